// File: rtl/vga_pkg.sv
// Shared VGA definitions: 7-segment pattern table, colour constants, RGB payload
// and the game-state encoding used by the top-level FSM.
// No ports (package).
package vga_pkg;

    localparam int unsigned RGB_W   = 12;
    localparam int unsigned SEG_N   = 7;
    localparam int unsigned COORD_W = 10;

    localparam logic [RGB_W-1:0] BLACK = 12'h000;
    localparam logic [RGB_W-1:0] WHITE = 12'hFFF;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb_t;

    typedef enum logic [1:0] {
        GS_IDLE  = 2'd0,
        GS_PLAY  = 2'd1,
        GS_PAUSE = 2'd2,
        GS_OVER  = 2'd3
    } game_state_e;

    // Segment mask {g,f,e,d,c,b,a}; 10-15 render as a blank digit.
    function automatic logic [SEG_N-1:0] seg7_pattern(input logic [3:0] value);
        case (value)
            4'd0:    return 7'h3F;
            4'd1:    return 7'h06;
            4'd2:    return 7'h5B;
            4'd3:    return 7'h4F;
            4'd4:    return 7'h66;
            4'd5:    return 7'h6D;
            4'd6:    return 7'h7D;
            4'd7:    return 7'h07;
            4'd8:    return 7'h7F;
            4'd9:    return 7'h6F;
            default: return 7'h00;
        endcase
    endfunction

endpackage

// File: rtl/vga_digit_renderer_if.sv
// Pixel-stream bus between the sync counter / RGB mux and the digit renderer.
//   pix_en, h_cnt, v_cnt, valid, vsync : timing from the sync counter
//   vgaRed, vgaGreen, vgaBlue, pix_hit : renderer output, aligned with each other
// master = timing source / RGB consumer, slave = renderer.
interface vga_digit_renderer_if;

    logic       pix_en;
    logic [9:0] h_cnt;
    logic [9:0] v_cnt;
    logic       valid;
    logic       vsync;
    logic [3:0] vgaRed;
    logic [3:0] vgaGreen;
    logic [3:0] vgaBlue;
    logic       pix_hit;

    modport master (
        output pix_en, h_cnt, v_cnt, valid, vsync,
        input  vgaRed, vgaGreen, vgaBlue, pix_hit
    );

    modport slave (
        input  pix_en, h_cnt, v_cnt, valid, vsync,
        output vgaRed, vgaGreen, vgaBlue, pix_hit
    );

endinterface

// File: rtl/vga_seg7_decode.sv
// Combinational 4-bit value -> 7-segment mask {g,f,e,d,c,b,a}.
//   value : digit value 0-15
//   seg_c : lit-segment mask, all zero for 10-15
module vga_seg7_decode
    import vga_pkg::*;
(
    input  logic [3:0]       value,
    output logic [SEG_N-1:0] seg_c
);

    assign seg_c = seg7_pattern(value);

endmodule

// File: rtl/vga_digit_renderer.sv
// Draws NUM_DIGITS seven-segment digits into the VGA pixel stream.
// Digit values, blink mask and disp_en are shadowed at each vsync falling edge
// so a frame never tears; 2-stage pixel pipeline advanced by pix_en.
//   clk, rst_n  : clock, synchronous active-low reset
//   vga         : pixel bus (timing in, RGB + pix_hit out)
//   digits_in   : digit i at [4i+3:4i], index 0 leftmost
//   blink_mask  : 1 = digit blinks
//   disp_en     : 0 = renderer outputs black
module vga_digit_renderer
    import vga_pkg::*;
#(
    parameter int unsigned     NUM_DIGITS   = 2,
    parameter int unsigned     X0           = 275,
    parameter int unsigned     Y0           = 190,
    parameter int unsigned     PITCH        = 65,
    parameter int unsigned     DIG_W        = 50,
    parameter int unsigned     DIG_H        = 90,
    parameter int unsigned     SEG_W        = 10,
    parameter logic [RGB_W-1:0] FG_COLOR    = WHITE,
    parameter int unsigned     BLINK_FRAMES = 30,
    parameter bit              LZ_BLANK     = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    vga_digit_renderer_if.slave     vga,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]   blink_mask,
    input  logic                    disp_en
);

    localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned FC_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam int unsigned MID   = (DIG_H - SEG_W) / 2;

    logic                    vs_q;
    logic [4*NUM_DIGITS-1:0] digits_q, digits_d;
    logic [NUM_DIGITS-1:0]   blink_q, blink_d;
    logic [NUM_DIGITS-1:0]   lz_q, lz_d;
    logic                    disp_en_q, disp_en_d;
    logic [FC_W-1:0]         frame_cnt_q, frame_cnt_d;
    logic                    blink_phase_q, blink_phase_d;
    logic                    s1_valid_q, s1_valid_d;
    logic                    s1_in_box_q, s1_in_box_d;
    logic [IDX_W-1:0]        s1_idx_q, s1_idx_d;
    logic [COORD_W-1:0]      s1_lx_q, s1_lx_d;
    logic [COORD_W-1:0]      s1_ly_q, s1_ly_d;
    rgb_t                    rgb_q, rgb_d;
    logic                    hit_q, hit_d;

    logic                    vs_fall_c;
    logic                    zero_run_c;
    logic [NUM_DIGITS-1:0]   lz_new_c;
    logic                    box_hit_c;
    logic [IDX_W-1:0]        box_idx_c;
    logic [COORD_W-1:0]      box_lx_c, box_ly_c;
    logic [3:0]              sel_digit_c;
    logic                    sel_blank_c;
    logic [SEG_N-1:0]        seg_c;
    logic [SEG_N-1:0]        cover_c;
    logic                    lit_c;

    assign vs_fall_c = vs_q & ~vga.vsync;

    // Leading-zero mask from the incoming digits; the last digit is never blanked.
    always_comb begin
        zero_run_c = 1'b1;
        lz_new_c   = '0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            zero_run_c  = zero_run_c & (digits_in[4*i +: 4] == 4'h0);
            lz_new_c[i] = LZ_BLANK && (i < NUM_DIGITS - 1) && zero_run_c;
        end
    end

    // Box search is done on raw counters so the subtraction below never wraps.
    always_comb begin
        box_hit_c = 1'b0;
        box_idx_c = '0;
        box_lx_c  = '0;
        box_ly_c  = '0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (vga.h_cnt >= COORD_W'(X0 + PITCH * i) &&
                vga.h_cnt <  COORD_W'(X0 + PITCH * i + DIG_W) &&
                vga.v_cnt >= COORD_W'(Y0) &&
                vga.v_cnt <  COORD_W'(Y0 + DIG_H)) begin
                box_hit_c = 1'b1;
                box_idx_c = IDX_W'(i);
                box_lx_c  = vga.h_cnt - COORD_W'(X0 + PITCH * i);
                box_ly_c  = vga.v_cnt - COORD_W'(Y0);
            end
        end
    end

    // Shadow value and blanking for the digit held in stage 1.
    always_comb begin
        sel_digit_c = 4'h0;
        sel_blank_c = 1'b0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (s1_idx_q == IDX_W'(i)) begin
                sel_digit_c = digits_q[4*i +: 4];
                sel_blank_c = lz_q[i] | (blink_q[i] & blink_phase_q);
            end
        end
    end

    vga_seg7_decode u_decode (
        .value (sel_digit_c),
        .seg_c (seg_c)
    );

    // Segment regions within the digit box, bit order {g,f,e,d,c,b,a}.
    always_comb begin
        cover_c[0] = s1_ly_q < COORD_W'(SEG_W);
        cover_c[1] = (s1_lx_q >= COORD_W'(DIG_W - SEG_W)) && (s1_ly_q < COORD_W'(MID + SEG_W));
        cover_c[2] = (s1_lx_q >= COORD_W'(DIG_W - SEG_W)) && (s1_ly_q >= COORD_W'(MID));
        cover_c[3] = s1_ly_q >= COORD_W'(DIG_H - SEG_W);
        cover_c[4] = (s1_lx_q < COORD_W'(SEG_W)) && (s1_ly_q >= COORD_W'(MID));
        cover_c[5] = (s1_lx_q < COORD_W'(SEG_W)) && (s1_ly_q < COORD_W'(MID + SEG_W));
        cover_c[6] = (s1_ly_q >= COORD_W'(MID)) && (s1_ly_q < COORD_W'(MID + SEG_W));
    end

    assign lit_c = s1_valid_q & s1_in_box_q & disp_en_q & ~sel_blank_c & (|(cover_c & seg_c));

    // Next state: frame latch, blink counter, pixel pipeline.
    always_comb begin
        digits_d      = digits_q;
        blink_d       = blink_q;
        lz_d          = lz_q;
        disp_en_d     = disp_en_q;
        frame_cnt_d   = frame_cnt_q;
        blink_phase_d = blink_phase_q;
        s1_valid_d    = s1_valid_q;
        s1_in_box_d   = s1_in_box_q;
        s1_idx_d      = s1_idx_q;
        s1_lx_d       = s1_lx_q;
        s1_ly_d       = s1_ly_q;
        rgb_d         = rgb_q;
        hit_d         = hit_q;

        if (vs_fall_c) begin
            digits_d  = digits_in;
            blink_d   = blink_mask;
            lz_d      = lz_new_c;
            disp_en_d = disp_en;
            if (frame_cnt_q == FC_W'(BLINK_FRAMES - 1)) begin
                frame_cnt_d   = '0;
                blink_phase_d = ~blink_phase_q;
            end else begin
                frame_cnt_d = frame_cnt_q + FC_W'(1);
            end
        end

        if (vga.pix_en) begin
            s1_valid_d  = vga.valid;
            s1_in_box_d = box_hit_c;
            s1_idx_d    = box_idx_c;
            s1_lx_d     = box_lx_c;
            s1_ly_d     = box_ly_c;
            rgb_d       = lit_c ? rgb_t'(FG_COLOR) : rgb_t'(BLACK);
            hit_d       = lit_c;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vs_q          <= 1'b0;
            digits_q      <= '0;
            blink_q       <= '0;
            lz_q          <= '0;
            disp_en_q     <= 1'b0;
            frame_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            s1_valid_q    <= 1'b0;
            s1_in_box_q   <= 1'b0;
            s1_idx_q      <= '0;
            s1_lx_q       <= '0;
            s1_ly_q       <= '0;
            rgb_q         <= '0;
            hit_q         <= 1'b0;
        end else begin
            vs_q          <= vga.vsync;
            digits_q      <= digits_d;
            blink_q       <= blink_d;
            lz_q          <= lz_d;
            disp_en_q     <= disp_en_d;
            frame_cnt_q   <= frame_cnt_d;
            blink_phase_q <= blink_phase_d;
            s1_valid_q    <= s1_valid_d;
            s1_in_box_q   <= s1_in_box_d;
            s1_idx_q      <= s1_idx_d;
            s1_lx_q       <= s1_lx_d;
            s1_ly_q       <= s1_ly_d;
            rgb_q         <= rgb_d;
            hit_q         <= hit_d;
        end
    end

    assign vga.vgaRed   = rgb_q.r;
    assign vga.vgaGreen = rgb_q.g;
    assign vga.vgaBlue  = rgb_q.b;
    assign vga.pix_hit  = hit_q;

endmodule

// File: tb/tb_vga_digit_renderer.sv
// Self-checking bench for vga_digit_renderer: two instances (2 digits, no LZ
// blanking, 2-frame blink; 3 digits, LZ blanking, other geometry) share one
// pixel stream and are compared against a geometric reference model.
module tb_vga_digit_renderer;

    localparam int A_ND = 2, A_X0 = 275, A_Y0 = 190, A_P = 65, A_W = 50, A_H = 90, A_S = 10, A_BF = 2;
    localparam int B_ND = 3, B_X0 = 100, B_Y0 = 50,  B_P = 70, B_W = 40, B_H = 60, B_S = 8,  B_BF = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pix_en;
    logic [9:0]  h_cnt;
    logic [9:0]  v_cnt;
    logic        valid;
    logic        vsync;
    logic        disp_en;
    logic [7:0]  dig_a;
    logic [1:0]  blink_a;
    logic [11:0] dig_b;
    logic [2:0]  blink_b;

    always #5 clk = ~clk;

    vga_digit_renderer_if if_a ();
    vga_digit_renderer_if if_b ();

    assign if_a.pix_en = pix_en;
    assign if_a.h_cnt  = h_cnt;
    assign if_a.v_cnt  = v_cnt;
    assign if_a.valid  = valid;
    assign if_a.vsync  = vsync;
    assign if_b.pix_en = pix_en;
    assign if_b.h_cnt  = h_cnt;
    assign if_b.v_cnt  = v_cnt;
    assign if_b.valid  = valid;
    assign if_b.vsync  = vsync;

    vga_digit_renderer #(
        .NUM_DIGITS(A_ND), .X0(A_X0), .Y0(A_Y0), .PITCH(A_P), .DIG_W(A_W), .DIG_H(A_H),
        .SEG_W(A_S), .FG_COLOR(12'hFFF), .BLINK_FRAMES(A_BF), .LZ_BLANK(1'b0)
    ) u_dut_a (
        .clk(clk), .rst_n(rst_n), .vga(if_a.slave),
        .digits_in(dig_a), .blink_mask(blink_a), .disp_en(disp_en)
    );

    vga_digit_renderer #(
        .NUM_DIGITS(B_ND), .X0(B_X0), .Y0(B_Y0), .PITCH(B_P), .DIG_W(B_W), .DIG_H(B_H),
        .SEG_W(B_S), .FG_COLOR(12'hFFF), .BLINK_FRAMES(B_BF), .LZ_BLANK(1'b1)
    ) u_dut_b (
        .clk(clk), .rst_n(rst_n), .vga(if_b.slave),
        .digits_in(dig_b), .blink_mask(blink_b), .disp_en(disp_en)
    );

    logic [11:0] rgb_a_w, rgb_b_w;
    assign rgb_a_w = {if_a.vgaRed, if_a.vgaGreen, if_a.vgaBlue};
    assign rgb_b_w = {if_b.vgaRed, if_b.vgaGreen, if_b.vgaBlue};

    int n_checks = 0;
    int n_errors = 0;

    // Reference state: shadows as seen by the renderer, vsync fall count, pixel in flight.
    int          falls;
    bit          sh_disp;
    logic [7:0]  sh_dig_a;
    logic [1:0]  sh_blink_a;
    logic [11:0] sh_dig_b;
    logic [2:0]  sh_blink_b;
    int          p_h, p_v;
    bit          p_vld;
    logic [11:0] exp_a, exp_b;

    string seg_str [10] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg",
                            "acdfg", "acdefg", "abc", "abcdefg", "abcdfg"};

    task automatic check(input string tag, input logic [11:0] got, input logic [11:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%03h exp=%03h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit seg_covers(byte s, int lx, int ly, int dw, int dh, int sw);
        int mid;
        mid = (dh - sw) / 2;
        case (s)
            "a":     return ly < sw;
            "b":     return lx >= dw - sw && ly < mid + sw;
            "c":     return lx >= dw - sw && ly >= mid;
            "d":     return ly >= dh - sw;
            "e":     return lx < sw && ly >= mid;
            "f":     return lx < sw && ly < mid + sw;
            "g":     return ly >= mid && ly < mid + sw;
            default: return 1'b0;
        endcase
    endfunction

    function automatic bit ref_lit(int h, int v, bit vld, bit disp, int nd, int x0, int y0,
                                   int pitch, int dw, int dh, int sw, bit lz, bit phase,
                                   logic [11:0] digs, logic [2:0] blink);
        if (!vld || !disp) return 1'b0;
        for (int i = 0; i < nd; i++) begin
            int left;
            left = x0 + i * pitch;
            if (h >= left && h < left + dw && v >= y0 && v < y0 + dh) begin
                int    val;
                bit    allz;
                string segs;
                val = int'(digs[4*i +: 4]);
                if (blink[i] && phase) return 1'b0;
                allz = 1'b1;
                for (int j = 0; j <= i; j++)
                    if (digs[4*j +: 4] != 4'h0) allz = 1'b0;
                if (lz && i < nd - 1 && allz) return 1'b0;
                if (val > 9) return 1'b0;
                segs = seg_str[val];
                for (int k = 0; k < segs.len(); k++)
                    if (seg_covers(segs[k], h - left, v - y0, dw, dh, sw)) return 1'b1;
                return 1'b0;
            end
        end
        return 1'b0;
    endfunction

    task automatic check_outputs(input string tag);
        check({tag, "_rgb_a"}, rgb_a_w, exp_a);
        check({tag, "_hit_a"}, 12'(if_a.pix_hit), (exp_a != 12'h0) ? 12'h1 : 12'h0);
        check({tag, "_rgb_b"}, rgb_b_w, exp_b);
        check({tag, "_hit_b"}, 12'(if_b.pix_hit), (exp_b != 12'h0) ? 12'h1 : 12'h0);
    endtask

    // One clock: present a pixel; an enabled tick shows the previously presented pixel.
    task automatic tick(input int h, input int v, input bit vld, input bit en);
        h_cnt  = 10'(h);
        v_cnt  = 10'(v);
        valid  = vld;
        pix_en = en;
        @(posedge clk);
        if (en) begin
            exp_a = ref_lit(p_h, p_v, p_vld, sh_disp, A_ND, A_X0, A_Y0, A_P, A_W, A_H, A_S,
                            1'b0, ((falls / A_BF) % 2) == 1, {4'h0, sh_dig_a}, {1'b0, sh_blink_a})
                    ? 12'hFFF : 12'h000;
            exp_b = ref_lit(p_h, p_v, p_vld, sh_disp, B_ND, B_X0, B_Y0, B_P, B_W, B_H, B_S,
                            1'b1, ((falls / B_BF) % 2) == 1, sh_dig_b, sh_blink_b)
                    ? 12'hFFF : 12'h000;
            p_h   = h;
            p_v   = v;
            p_vld = vld;
        end
        @(negedge clk);
        check_outputs("px");
    endtask

    task automatic frame_edge();
        pix_en = 1'b0;
        vsync  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        vsync = 1'b0;
        @(posedge clk);
        sh_disp    = disp_en;
        sh_dig_a   = dig_a;
        sh_blink_a = blink_a;
        sh_dig_b   = dig_b;
        sh_blink_b = blink_b;
        falls++;
        @(negedge clk);
        vsync = 1'b1;
        check_outputs("vs_hold");
    endtask

    task automatic do_reset();
        rst_n  = 1'b0;
        pix_en = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        exp_a = 12'h0; exp_b = 12'h0;
        p_vld = 1'b0;  falls = 0;  sh_disp = 1'b0;
        sh_dig_a = '0; sh_blink_a = '0; sh_dig_b = '0; sh_blink_b = '0;
        check_outputs("reset");
        rst_n = 1'b1;
    endtask

    function automatic logic [3:0] rand_nib();
        return ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
    endfunction

    bit blink_on [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

    initial begin
        rst_n = 1'b0; pix_en = 1'b0; h_cnt = '0; v_cnt = '0; valid = 1'b0; vsync = 1'b1;
        disp_en = 1'b0; dig_a = '0; blink_a = '0; dig_b = '0; blink_b = '0;
        p_h = 0; p_v = 0;
        @(negedge clk);
        do_reset();

        // Nothing latched yet: black even with disp_en high.
        disp_en = 1'b1; dig_a = 8'h88; dig_b = 12'h888;
        tick(300, 195, 1, 1); tick(360, 195, 1, 1); tick(300, 195, 1, 1);
        check("pre_latch_black", rgb_a_w, 12'h000);

        // Digit 0 = 4 (no a), digit 1 = 2 (has a); two-tick latency.
        dig_a = 8'h24;
        frame_edge();
        tick(295, 195, 1, 1); tick(360, 195, 1, 1);
        check("dec_d0_no_a", rgb_a_w, 12'h000);
        tick(0, 0, 0, 1);
        check("dec_d1_a", rgb_a_w, 12'hFFF);
        tick(0, 0, 0, 0); tick(0, 0, 0, 0);
        check("gap_hold", rgb_a_w, 12'hFFF);
        tick(360, 195, 0, 1); tick(0, 0, 0, 1);
        check("valid_low_black", rgb_a_w, 12'h000);

        // Mid-frame change waits for the next vsync fall.
        dig_a = 8'h99;
        tick(295, 195, 1, 1); tick(0, 0, 0, 1);
        check("tear_old_value", rgb_a_w, 12'h000);
        frame_edge();
        tick(295, 195, 1, 1); tick(0, 0, 0, 1);
        check("tear_new_value", rgb_a_w, 12'hFFF);

        // Value 0xB is a blank box.
        dig_a = 8'hB9;
        frame_edge();
        tick(360, 195, 1, 1); tick(345, 235, 1, 1);
        check("blank_b_a", rgb_a_w, 12'h000);
        tick(0, 0, 0, 1);
        check("blank_b_e", rgb_a_w, 12'h000);

        // Reset mid-frame: black and shadows cleared.
        tick(295, 195, 1, 1);
        do_reset();
        tick(295, 195, 1, 1); tick(0, 0, 0, 1);
        check("post_reset_black", rgb_a_w, 12'h000);

        // Blink digit 1 with a 2-frame half period.
        dig_a = 8'h24; blink_a = 2'b10; disp_en = 1'b1;
        for (int f = 0; f < 6; f++) begin
            frame_edge();
            tick(360, 195, 1, 1); tick(320, 200, 1, 1);
            check("blink_d1", rgb_a_w, blink_on[f] ? 12'hFFF : 12'h000);
            tick(0, 0, 0, 1);
            check("blink_d0", rgb_a_w, 12'hFFF);
        end
        blink_a = 2'b00;

        // Leading-zero blanking on the 3-digit instance.
        dig_b = 12'h700;
        frame_edge();
        tick(110, 52, 1, 1); tick(180, 52, 1, 1);
        check("lz700_d0", rgb_b_w, 12'h000);
        tick(250, 52, 1, 1);
        check("lz700_d1", rgb_b_w, 12'h000);
        tick(0, 0, 0, 1);
        check("lz700_d2", rgb_b_w, 12'hFFF);
        dig_b = 12'h000;
        frame_edge();
        tick(110, 52, 1, 1); tick(250, 52, 1, 1);
        check("lz000_d0", rgb_b_w, 12'h000);
        tick(0, 0, 0, 1);
        check("lz000_d2", rgb_b_w, 12'hFFF);
        dig_b = 12'h070;
        frame_edge();
        tick(110, 52, 1, 1); tick(180, 52, 1, 1);
        check("lz070_d0", rgb_b_w, 12'h000);
        tick(250, 52, 1, 1);
        check("lz070_d1", rgb_b_w, 12'hFFF);
        tick(0, 0, 0, 1);
        check("lz070_d2", rgb_b_w, 12'hFFF);

        // Randomised frames with mid-frame input churn.
        for (int fr = 0; fr < 12; fr++) begin
            dig_a   = {rand_nib(), rand_nib()};
            dig_b   = {rand_nib(), rand_nib(), rand_nib()};
            blink_a = 2'($urandom_range(0, 3));
            blink_b = 3'($urandom_range(0, 7));
            disp_en = ($urandom_range(0, 3) != 0);
            frame_edge();
            for (int n = 0; n < 250; n++) begin
                if (n == 120) begin
                    dig_a   = {rand_nib(), rand_nib()};
                    dig_b   = {rand_nib(), rand_nib(), rand_nib()};
                    disp_en = ~disp_en;
                end
                tick(int'($urandom_range(90, 400)), int'($urandom_range(40, 290)),
                     $urandom_range(0, 9) != 0, $urandom_range(0, 3) != 0);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
